mest_pro_sequencer: RTL and testbench

Program sequencer and execute unit of the MESTPro core. On a start pulse it fetches 28-bit instructions from the program ROM at address 0 upward and executes each on an 8-bit ALU. Every result-producing instruction is reported with a one-cycle valid pulse plus carry and zero flags. It raises all-done on HALT or at the end of ROM. It is the responder side of the start/result/all-done interface driven and monitored by the processor testbench.

---
 rtl/mest_pro_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mest_pro_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mest_pro_sequencer.sv
// mest_pro_sequencer: program sequencer and 8-bit execute unit of the MESTPro core.
// After a start pulse it fetches instructions from the program ROM beginning at
// address 0 and executes one every three cycles (FETCH, WAIT, EXEC).
// Optional build macro: MEST_SEQ_INSTR_COUNT_EN adds the o_instr_count output.
//
// Ports:
//   clk            system clock, rising edge
//   i_reset        synchronous active-high reset
//   i_start        one-cycle pulse that starts the program from address 0
//   o_rom_addr     ROM read address (the program counter)
//   o_rom_en       ROM read enable; data returns one cycle later
//   i_rom_data     instruction word {op, A, B, C}
//   o_result       ALU result, held between pulses
//   o_valid_result one-cycle pulse qualifying o_result/o_carry/o_zero_flag
//   o_carry        carry / borrow / shift-out flag
//   o_zero_flag    high when o_result == 0
//   o_all_done     program finished; held until reset or a new start
//   o_busy         high from the accepted start until DONE is entered
//   o_instr_count  executed-instruction count (MEST_SEQ_INSTR_COUNT_EN only)

module mest_pro_sequencer #(
  parameter int unsigned OP_CODE_SIZE     = 4,
  parameter int unsigned INSTRUCTION_SIZE = OP_CODE_SIZE + 24,
  parameter int unsigned ROM_DEPTH        = 65536,
  localparam int unsigned ADDR_W          = $clog2(ROM_DEPTH)
) (
  input  logic                        clk,
  input  logic                        i_reset,
  input  logic                        i_start,
  output logic [ADDR_W-1:0]           o_rom_addr,
  output logic                        o_rom_en,
  input  logic [INSTRUCTION_SIZE-1:0] i_rom_data,
  output logic [7:0]                  o_result,
  output logic                        o_valid_result,
  output logic                        o_carry,
  output logic                        o_zero_flag,
  output logic                        o_all_done,
  output logic                        o_busy
`ifdef MEST_SEQ_INSTR_COUNT_EN
  ,
  output logic [15:0]                 o_instr_count
`endif
);

  localparam int unsigned DATA_W = 8;

  localparam logic [OP_CODE_SIZE-1:0] OP_ADD  = OP_CODE_SIZE'(1);
  localparam logic [OP_CODE_SIZE-1:0] OP_SUB  = OP_CODE_SIZE'(2);
  localparam logic [OP_CODE_SIZE-1:0] OP_AND  = OP_CODE_SIZE'(3);
  localparam logic [OP_CODE_SIZE-1:0] OP_OR   = OP_CODE_SIZE'(4);
  localparam logic [OP_CODE_SIZE-1:0] OP_XOR  = OP_CODE_SIZE'(5);
  localparam logic [OP_CODE_SIZE-1:0] OP_ADC  = OP_CODE_SIZE'(6);
  localparam logic [OP_CODE_SIZE-1:0] OP_SHL  = OP_CODE_SIZE'(7);
  localparam logic [OP_CODE_SIZE-1:0] OP_SHR  = OP_CODE_SIZE'(8);
  localparam logic [OP_CODE_SIZE-1:0] OP_CMP  = OP_CODE_SIZE'(9);
  localparam logic [OP_CODE_SIZE-1:0] OP_MOV  = OP_CODE_SIZE'(10);
  localparam logic [OP_CODE_SIZE-1:0] OP_HALT = OP_CODE_SIZE'(15);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [INSTRUCTION_SIZE-1:0] ir;
  logic [ADDR_W-1:0]           pc;
  logic                        carry_q;

  // Instruction fields
  logic [OP_CODE_SIZE-1:0] op;
  logic [DATA_W-1:0]       fld_a;
  logic [DATA_W-1:0]       fld_b;
  logic [DATA_W-1:0]       fld_c;

  assign op    = ir[INSTRUCTION_SIZE-1 -: OP_CODE_SIZE];
  assign fld_a = ir[23:16];
  assign fld_b = ir[15:8];
  assign fld_c = ir[7:0];

  assign o_rom_addr = pc;

  // Next values of the registered outputs and datapath
  logic              start_accept;
  logic              is_halt;
  logic              alu_valid;
  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              valid_d;
  logic              rom_en_d;
  logic              busy_d;
  logic              all_done_d;
  logic [ADDR_W-1:0] pc_d;

  // Wide intermediates; bit 8 carries the carry/borrow out
  logic [DATA_W:0]     sum_ab;
  logic [DATA_W:0]     sum_abc;
  logic [DATA_W:0]     diff_ab;
  logic [2*DATA_W-1:0] shl_w;
  logic [2*DATA_W-1:0] shr_w;

  // State register
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (i_start) state_next = S_FETCH;
      S_FETCH: state_next = S_WAIT;
      S_WAIT:  state_next = S_EXEC;
      S_EXEC: begin
        // The last ROM word is executed before stopping; no wrap to 0
        if ((op == OP_HALT) || (pc == LAST_ADDR)) begin
          state_next = S_DONE;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_DONE:  if (i_start) state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  // Output logic: ALU decode plus next values of all registered outputs
  always_comb begin
    start_accept = 1'b0;
    is_halt      = 1'b0;
    alu_valid    = 1'b0;
    alu_result   = '0;
    alu_carry    = 1'b0;
    valid_d      = 1'b0;
    rom_en_d     = 1'b0;
    busy_d       = 1'b0;
    all_done_d   = 1'b0;
    pc_d         = pc;

    sum_ab  = {1'b0, fld_a} + {1'b0, fld_b};
    sum_abc = {1'b0, fld_a} + {1'b0, fld_b} + {{DATA_W{1'b0}}, carry_q};
    diff_ab = {1'b0, fld_a} - {1'b0, fld_b};
    // Shift through a double-width word so the last bit out lands next to the result
    shl_w   = {{DATA_W{1'b0}}, fld_a} << fld_b[2:0];
    shr_w   = {fld_a, {DATA_W{1'b0}}} >> fld_b[2:0];

    case (op)
      OP_ADD: begin
        alu_valid  = 1'b1;
        alu_result = sum_ab[DATA_W-1:0];
        alu_carry  = sum_ab[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        alu_valid  = 1'b1;
        alu_result = diff_ab[DATA_W-1:0];
        alu_carry  = diff_ab[DATA_W];
      end
      OP_AND: begin
        alu_valid  = 1'b1;
        alu_result = fld_a & fld_b;
      end
      OP_OR: begin
        alu_valid  = 1'b1;
        alu_result = fld_a | fld_b;
      end
      OP_XOR: begin
        alu_valid  = 1'b1;
        alu_result = fld_a ^ fld_b;
      end
      OP_ADC: begin
        alu_valid  = 1'b1;
        alu_result = sum_abc[DATA_W-1:0];
        alu_carry  = sum_abc[DATA_W];
      end
      OP_SHL: begin
        alu_valid  = 1'b1;
        alu_result = shl_w[DATA_W-1:0];
        alu_carry  = shl_w[DATA_W];
      end
      OP_SHR: begin
        alu_valid  = 1'b1;
        alu_result = shr_w[2*DATA_W-1:DATA_W];
        alu_carry  = shr_w[DATA_W-1];
      end
      OP_MOV: begin
        alu_valid  = 1'b1;
        alu_result = fld_c;
      end
      OP_HALT: begin
        is_halt = 1'b1;
      end
      default: begin
        // NOP and reserved opcodes produce nothing
        alu_valid = 1'b0;
      end
    endcase

    start_accept = i_start && ((state == S_IDLE) || (state == S_DONE));
    valid_d      = (state == S_EXEC) && alu_valid;
    rom_en_d     = (state_next == S_FETCH);
    busy_d       = (state_next == S_FETCH) || (state_next == S_WAIT) ||
                   (state_next == S_EXEC);
    all_done_d   = (state_next == S_DONE);

    if (start_accept) begin
      pc_d = '0;
    end else if ((state == S_EXEC) && (state_next == S_FETCH)) begin
      pc_d = pc + ADDR_W'(1);
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (i_reset) begin
      pc             <= '0;
      ir             <= '0;
      carry_q        <= 1'b0;
      o_rom_en       <= 1'b0;
      o_result       <= '0;
      o_valid_result <= 1'b0;
      o_carry        <= 1'b0;
      o_zero_flag    <= 1'b0;
      o_all_done     <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      pc             <= pc_d;
      o_rom_en       <= rom_en_d;
      o_valid_result <= valid_d;
      o_all_done     <= all_done_d;
      o_busy         <= busy_d;

      if (state == S_WAIT) begin
        ir <= i_rom_data;
      end

      // Flags and carry register change only on result-producing instructions
      if (valid_d) begin
        o_result    <= alu_result;
        o_carry     <= alu_carry;
        o_zero_flag <= (alu_result == '0);
        carry_q     <= alu_carry;
      end else if (start_accept) begin
        carry_q     <= 1'b0;
      end
    end
  end

`ifdef MEST_SEQ_INSTR_COUNT_EN
  // Executed-instruction counter: NOP/reserved included, HALT excluded, saturating
  always_ff @(posedge clk) begin
    if (i_reset) begin
      o_instr_count <= '0;
    end else if (start_accept) begin
      o_instr_count <= '0;
    end else if ((state == S_EXEC) && !is_halt && (o_instr_count != 16'hFFFF)) begin
      o_instr_count <= o_instr_count + 16'd1;
    end
  end
`else
  // Without the counter, HALT detection is consumed only by the next-state logic
  logic unused_halt;
  assign unused_halt = is_halt;
`endif

endmodule

// File: tb/tb_mest_pro_sequencer.sv
// Directed self-checking bench for mest_pro_sequencer: one instance with the
// default ROM depth fed by a small synchronous ROM model, and one instance with
// ROM_DEPTH=4 fed a constant ADD 1,1 word to exercise the end-of-ROM stop.
module tb_mest_pro_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        i_reset, i_start;
  logic [15:0] rom_addr;
  logic        rom_en;
  logic [27:0] rom_data;
  logic [7:0]  result;
  logic        valid, carry, zero, all_done, busy;
`ifdef MEST_SEQ_INSTR_COUNT_EN
  logic [15:0] instr_count;
  logic [15:0] instr_count4;
`endif

  // Depth-4 instance
  logic        reset4, start4;
  logic [1:0]  rom_addr4;
  logic        rom_en4;
  logic [27:0] rom_data4;
  logic [7:0]  result4;
  logic        valid4, carry4, zero4, all_done4, busy4;

  mest_pro_sequencer dut (
    .clk(clk), .i_reset(i_reset), .i_start(i_start),
    .o_rom_addr(rom_addr), .o_rom_en(rom_en), .i_rom_data(rom_data),
    .o_result(result), .o_valid_result(valid), .o_carry(carry),
    .o_zero_flag(zero), .o_all_done(all_done), .o_busy(busy)
`ifdef MEST_SEQ_INSTR_COUNT_EN
    , .o_instr_count(instr_count)
`endif
  );

  mest_pro_sequencer #(.ROM_DEPTH(4)) dut4 (
    .clk(clk), .i_reset(reset4), .i_start(start4),
    .o_rom_addr(rom_addr4), .o_rom_en(rom_en4), .i_rom_data(rom_data4),
    .o_result(result4), .o_valid_result(valid4), .o_carry(carry4),
    .o_zero_flag(zero4), .o_all_done(all_done4), .o_busy(busy4)
`ifdef MEST_SEQ_INSTR_COUNT_EN
    , .o_instr_count(instr_count4)
`endif
  );

  function automatic logic [27:0] ins(input logic [3:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c);
    return {op, a, b, c};
  endfunction

  // Synchronous program ROM: data appears the cycle after the enable
  logic [27:0] rom [16];
  always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr[3:0]];
  assign rom_data4 = {4'd1, 8'd1, 8'd1, 8'd0};

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] r;
    logic       c;
    logic       z;
    int         cyc;
  } pulse_t;

  pulse_t pq[$];
  int     aq[$];
  int     done_cyc = -1;
  logic   done_prev = 1'b0;
  pulse_t p4[$];
  int     a4[$];
  int     done4_cyc = -1;
  logic   done4_prev = 1'b0;

  // Monitors sample mid-cycle
  always @(negedge clk) begin
    if (valid) pq.push_back('{result, carry, zero, cyc});
    if (rom_en) aq.push_back(int'(rom_addr));
    if (all_done && !done_prev) done_cyc = cyc;
    done_prev = all_done;
    if (valid4) p4.push_back('{result4, carry4, zero4, cyc});
    if (rom_en4) a4.push_back(int'(rom_addr4));
    if (all_done4 && !done4_prev) done4_cyc = cyc;
    done4_prev = all_done4;
  end

  int ntests = 0;
  int nfail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pulse(input string tag, input int idx, input logic [7:0] r,
                           input logic c, input logic z);
    if (pq.size() > idx) begin
      chk({tag, ".result"}, 32'(pq[idx].r), 32'(r));
      chk({tag, ".carry"},  32'(pq[idx].c), 32'(c));
      chk({tag, ".zero"},   32'(pq[idx].z), 32'(z));
    end else begin
      chk({tag, ".present"}, 32'(pq.size()), 32'(idx + 1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !all_done; i++) tick();
    chk({tag, ".done"}, 32'(all_done), 32'd1);
  endtask

  task automatic clr();
    pq.delete();
    aq.delete();
    done_cyc = -1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".result"},   32'(result),   32'd0);
    chk({tag, ".valid"},    32'(valid),    32'd0);
    chk({tag, ".carry"},    32'(carry),    32'd0);
    chk({tag, ".zero"},     32'(zero),     32'd0);
    chk({tag, ".all_done"}, 32'(all_done), 32'd0);
    chk({tag, ".busy"},     32'(busy),     32'd0);
    chk({tag, ".rom_en"},   32'(rom_en),   32'd0);
    chk({tag, ".rom_addr"}, 32'(rom_addr), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    i_reset = 1'b1; i_start = 1'b0;
    reset4  = 1'b1; start4  = 1'b0;
    for (int i = 0; i < 16; i++) rom[i] = ins(4'd15, 8'd0, 8'd0, 8'd0);
    tick(); tick();
    i_reset = 1'b0; reset4 = 1'b0;
    tick();
    chk_all_zero("reset");

    // ADD 200,100 then HALT
    rom[0] = ins(4'd1, 8'd200, 8'd100, 8'd0);
    rom[1] = ins(4'd15, 8'd0, 8'd0, 8'd0);
    clr();
    start_pulse();
    chk("t1.busy_after_start", 32'(busy), 32'd1);
    wait_done("t1", 40);
    tick(); tick(); tick();
    chk("t1.npulses", 32'(pq.size()), 32'd1);
    chk_pulse("t1.p0", 0, 8'd44, 1'b1, 1'b0);
    chk("t1.done_lag", 32'(done_cyc - pq[0].cyc), 32'd3);
    chk("t1.nfetch", 32'(aq.size()), 32'd2);
    chk("t1.fetch0", 32'(aq[0]), 32'd0);
    chk("t1.fetch1", 32'(aq[1]), 32'd1);
    chk("t1.result_hold", 32'(result), 32'd44);
    chk("t1.done_hold", 32'(all_done), 32'd1);
    chk("t1.busy_done", 32'(busy), 32'd0);

    // SUB/SUB/ADC, restarted from DONE
    rom[0] = ins(4'd2, 8'd5, 8'd5, 8'd0);
    rom[1] = ins(4'd2, 8'd3, 8'd4, 8'd0);
    rom[2] = ins(4'd6, 8'd1, 8'd1, 8'd0);
    rom[3] = ins(4'd15, 8'd0, 8'd0, 8'd0);
    clr();
    start_pulse();
    chk("t2.done_drop", 32'(all_done), 32'd0);
    chk("t2.busy", 32'(busy), 32'd1);
    wait_done("t2", 60);
    tick();
    chk("t2.npulses", 32'(pq.size()), 32'd3);
    chk_pulse("t2.p0", 0, 8'd0,   1'b0, 1'b1);
    chk_pulse("t2.p1", 1, 8'd255, 1'b1, 1'b0);
    chk_pulse("t2.p2", 2, 8'd3,   1'b0, 1'b0);
    chk("t2.gap01", 32'(pq[1].cyc - pq[0].cyc), 32'd3);
    chk("t2.gap12", 32'(pq[2].cyc - pq[1].cyc), 32'd3);

    // Shifts, MOV of zero, NOP
    rom[0] = ins(4'd7, 8'h81, 8'd1, 8'd0);
    rom[1] = ins(4'd8, 8'h01, 8'd1, 8'd0);
    rom[2] = ins(4'd10, 8'd7, 8'd9, 8'd0);
    rom[3] = ins(4'd0, 8'd1, 8'd1, 8'd1);
    rom[4] = ins(4'd15, 8'd0, 8'd0, 8'd0);
    clr();
    start_pulse();
    wait_done("t3", 60);
    tick();
    chk("t3.npulses", 32'(pq.size()), 32'd3);
    chk_pulse("t3.shl", 0, 8'h02, 1'b1, 1'b0);
    chk_pulse("t3.shr", 1, 8'h00, 1'b1, 1'b1);
    chk_pulse("t3.mov", 2, 8'h00, 1'b0, 1'b1);
    chk("t3.nop_halt_lag", 32'(done_cyc - pq[2].cyc), 32'd6);

    // Mid-run start is ignored
    rom[0] = ins(4'd1, 8'd200, 8'd100, 8'd0);
    rom[1] = ins(4'd2, 8'd3, 8'd4, 8'd0);
    rom[2] = ins(4'd15, 8'd0, 8'd0, 8'd0);
    clr();
    start_pulse();
    tick(); tick(); tick();
    start_pulse();
    wait_done("t5", 60);
    tick();
    chk("t5.npulses", 32'(pq.size()), 32'd2);
    chk_pulse("t5.p0", 0, 8'd44,  1'b1, 1'b0);
    chk_pulse("t5.p1", 1, 8'd255, 1'b1, 1'b0);
    chk("t5.nfetch", 32'(aq.size()), 32'd3);

    // NOP and reserved count as executed; HALT does not
    rom[0] = ins(4'd1, 8'd1, 8'd2, 8'd0);
    rom[1] = ins(4'd0, 8'd0, 8'd0, 8'd0);
    rom[2] = ins(4'd12, 8'd9, 8'd9, 8'd9);
    rom[3] = ins(4'd5, 8'hF0, 8'hFF, 8'd0);
    rom[4] = ins(4'd15, 8'd0, 8'd0, 8'd0);
    clr();
    start_pulse();
    wait_done("t6", 60);
    tick();
    chk("t6.npulses", 32'(pq.size()), 32'd2);
    chk_pulse("t6.add", 0, 8'd3,   1'b0, 1'b0);
    chk_pulse("t6.xor", 1, 8'h0F,  1'b0, 1'b0);
    chk("t6.nfetch", 32'(aq.size()), 32'd5);
`ifdef MEST_SEQ_INSTR_COUNT_EN
    chk("t6.instr_count", 32'(instr_count), 32'd4);
`endif

    // Reset during WAIT of the third instruction, then rerun
    rom[0] = ins(4'd6, 8'd1, 8'd1, 8'd0);
    rom[1] = ins(4'd1, 8'd200, 8'd100, 8'd0);
    rom[2] = ins(4'd6, 8'd1, 8'd1, 8'd0);
    rom[3] = ins(4'd15, 8'd0, 8'd0, 8'd0);
    clr();
    start_pulse();
    for (int i = 0; i < 20 && !(rom_en && rom_addr == 16'd2); i++) tick();
    chk("t7.reached_fetch2", 32'(rom_en && rom_addr == 16'd2), 32'd1);
    tick();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk_all_zero("t7.after_reset");
    chk("t7.pre_pulses", 32'(pq.size()), 32'd2);
    clr();
    for (int i = 0; i < 10; i++) tick();
    chk("t7.no_pulse", 32'(pq.size()), 32'd0);
    chk("t7.idle_busy", 32'(busy), 32'd0);
    start_pulse();
    wait_done("t7", 60);
    tick();
    chk("t7.npulses", 32'(pq.size()), 32'd3);
    chk_pulse("t7.adc0", 0, 8'd2,  1'b0, 1'b0);
    chk_pulse("t7.add",  1, 8'd44, 1'b1, 1'b0);
    chk_pulse("t7.adc1", 2, 8'd3,  1'b0, 1'b0);

    // Reset and start together: reset wins
    i_reset = 1'b1; i_start = 1'b1;
    tick();
    i_reset = 1'b0; i_start = 1'b0;
    chk("t8.all_done", 32'(all_done), 32'd0);
    chk("t8.busy", 32'(busy), 32'd0);
    tick(); tick();
    chk("t8.still_idle", 32'(busy), 32'd0);
    chk("t8.no_fetch", 32'(rom_en), 32'd0);

    // Depth-4 ROM without HALT stops after the last word
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 40 && !all_done4; i++) tick();
    chk("t4.done", 32'(all_done4), 32'd1);
    tick(); tick(); tick();
    chk("t4.npulses", 32'(p4.size()), 32'd4);
    for (int i = 0; i < 4 && i < p4.size(); i++) begin
      chk("t4.result", 32'(p4[i].r), 32'd2);
      chk("t4.carry",  32'(p4[i].c), 32'd0);
    end
    chk("t4.nfetch", 32'(a4.size()), 32'd4);
    for (int i = 0; i < 4 && i < a4.size(); i++) chk("t4.addr", 32'(a4[i]), 32'(i));
    chk("t4.done_with_last", 32'(done4_cyc), 32'(p4[3].cyc));
    chk("t4.busy", 32'(busy4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
